// File: rtl/alb_if.sv
`default_nettype none
// ============================================================================
// Module      : alb_if
// Description : Operand/result handshake bundle for the alb_pipe ALU stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alb_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] R_in;
    logic [WIDTH-1:0] S_in;
    logic             CI;
    logic [2:0]       I;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F_ALB;
    logic             CO;
    logic             VO;
    logic             NO;
    logic             ZO;

    modport master (
        output in_valid, R_in, S_in, CI, I, out_ready,
        input  in_ready, out_valid, F_ALB, CO, VO, NO, ZO
    );

    modport slave (
        input  in_valid, R_in, S_in, CI, I, out_ready,
        output in_ready, out_valid, F_ALB, CO, VO, NO, ZO
    );
endinterface
`default_nettype wire

// File: rtl/alb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alb_pipe
// Description : Handshaked WIDTH-bit ALU with registered result and flags.
//               Define ALB_SHIFT_EN to build the multi-cycle shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module alb_pipe #(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    alb_if.slave      bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALB_SHIFT_EN
        ST_BUSY = 2'd2,
`endif
        ST_HOLD = 2'd1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_f;
    logic             r_co;
    logic             r_vo;
    logic             r_no;
    logic             r_zo;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_f;
    logic             w_co;
    logic             w_vo;
    logic             w_sub;
    logic             w_accept;

    assign bus.in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.out_ready);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.F_ALB     = r_f;
    assign bus.CO        = r_co;
    assign bus.VO        = r_vo;
    assign bus.NO        = r_no;
    assign bus.ZO        = r_zo;

    assign w_accept = bus.in_valid && bus.in_ready;

    // Subtract is S + ~R + CI, so one adder serves both arithmetic opcodes.
    assign w_sub = (bus.I == 3'b000);
    assign w_b   = w_sub ? ~bus.R_in : bus.R_in;
    assign w_sum = {1'b0, bus.S_in} + {1'b0, w_b} + {{WIDTH{1'b0}}, bus.CI};

    always_comb begin
        w_f  = bus.S_in;
        w_co = 1'b0;
        w_vo = 1'b0;
        case (bus.I)
            3'b000: begin
                w_f  = w_sum[WIDTH-1:0];
                w_co = w_sum[WIDTH];
                w_vo = (bus.S_in[WIDTH-1] != bus.R_in[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.S_in[WIDTH-1]);
            end
            3'b010: begin
                w_f  = w_sum[WIDTH-1:0];
                w_co = w_sum[WIDTH];
                w_vo = (bus.S_in[WIDTH-1] == bus.R_in[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.S_in[WIDTH-1]);
            end
            3'b001:  w_f = bus.S_in | bus.R_in;
            3'b011:  w_f = ~(bus.S_in ^ bus.R_in);
            3'b100:  w_f = bus.S_in & bus.R_in;
            3'b101:  w_f = bus.S_in ^ bus.R_in;
            // Shifts by zero (or with the shifter absent) pass S through.
            default: w_f = bus.S_in;
        endcase
    end

`ifdef ALB_SHIFT_EN
    logic [WIDTH-1:0] r_sh;
    logic [SHW-1:0]   r_cnt;
    logic             r_dir;
    logic [SHW-1:0]   w_n;
    logic             w_start_shift;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_out;

    assign w_n           = bus.R_in[SHW-1:0];
    assign w_start_shift = (bus.I[2:1] == 2'b11) && (w_n != '0);
    // r_dir=1 is a right shift; the bit leaving the register is the carry.
    assign w_sh_next     = r_dir ? {1'b0, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};
    assign w_sh_out      = r_dir ? r_sh[0] : r_sh[WIDTH-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_f     <= '0;
            r_co    <= 1'b0;
            r_vo    <= 1'b0;
            r_no    <= 1'b0;
            r_zo    <= 1'b0;
`ifdef ALB_SHIFT_EN
            r_sh    <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
`ifdef ALB_SHIFT_EN
                if (w_start_shift) begin
                    r_state <= ST_BUSY;
                    r_sh    <= bus.S_in;
                    r_cnt   <= w_n;
                    r_dir   <= bus.I[0];
                end else
`endif
                begin
                    r_state <= ST_HOLD;
                    r_f     <= w_f;
                    r_co    <= w_co;
                    r_vo    <= w_vo;
                    r_no    <= w_f[WIDTH-1];
                    r_zo    <= (w_f == '0);
                end
            end
`ifdef ALB_SHIFT_EN
            else if (r_state == ST_BUSY) begin
                r_sh  <= w_sh_next;
                r_cnt <= r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    r_state <= ST_HOLD;
                    r_f     <= w_sh_next;
                    r_co    <= w_sh_out;
                    r_vo    <= 1'b0;
                    r_no    <= w_sh_next[WIDTH-1];
                    r_zo    <= (w_sh_next == '0);
                end
            end
`endif
            else if ((r_state == ST_HOLD) && bus.out_ready) begin
                r_state <= ST_IDLE;
            end
        end
    end
endmodule
`default_nettype wire
